light_pen_locator: RTL

LIGHT_PEN_LOCATOR -- requirements
Module: light_pen_locator

---
 rtl/light_pen_locator_pkg.sv | 23 ++
 rtl/light_pen_locator_pen_edge_sync.sv | 20 ++
 rtl/light_pen_locator.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/light_pen_locator_pkg.sv
// light_pen_locator_pkg: locator FSM states, LED RAM word bit positions and scan-vector helpers
package light_pen_locator_pkg;

    typedef enum logic [2:0] {IDLE, SEARCH, CONFIRM, WRITE, HOLD} state_t;

    localparam int LIT = 3;
    localparam int RED = 1;
    localparam int GRN = 2;

    function automatic logic onehot8(input logic [7:0] v);
        return v != 8'd0 && (v & (v - 8'd1)) == 8'd0;
    endfunction

    function automatic logic [2:0] enc8(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i])
                r = 3'(i);
        return r;
    endfunction

endpackage

// File: rtl/light_pen_locator_pen_edge_sync.sv
// pen_edge_sync: two-flop synchronizer plus registered rising-edge detect, three cycles from pen_in to pen_edge
module pen_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic pen_in,
    output logic pen_edge
);

    logic [2:0] s;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s <= '0;
            pen_edge <= 1'b0;
        end else begin
            s <= {s[1:0], pen_in};
            pen_edge <= s[1] & ~s[2];
        end

endmodule

// File: rtl/light_pen_locator.sv
// light_pen_locator: locates the light pen on the scanned matrix and writes confirmed pixels; LIGHT_PEN_ERASE_EN enables erase
module light_pen_locator
    import light_pen_locator_pkg::*;
#(
    parameter int LATENCY        = 3,
    parameter int CONFIRM_FRAMES = 2,
    parameter int RELEASE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] led_row,
    input  logic [7:0] led_col,
    input  logic       pen_in,
    input  logic [1:0] color_sel,
    input  logic       erase,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic [3:0] wr_data,
    output logic       pen_locked
);

    localparam logic [7:0] CF = 8'(CONFIRM_FRAMES);
    localparam logic [7:0] RF = 8'(RELEASE_FRAMES);

    state_t      state, state_n;
    logic        pen_edge, boundary, hit, same, f_hit;
    logic [7:0]  d_row, d_col, prev_row, cnt, cnt_n, rel, rel_n;
    logic [15:0] d_rc;
    logic [5:0]  f_pos, pos, pos_n;
    logic [3:0]  word, wr_word;

    pen_edge_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .pen_in   (pen_in),
        .pen_edge (pen_edge)
    );

    generate
        if (LATENCY == 0) begin : g_nodly
            assign d_rc = {led_row, led_col};
        end else begin : g_dly
            logic [15:0] dl [LATENCY];
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    for (int i = 0; i < LATENCY; i++)
                        dl[i] <= '0;
                end else begin
                    dl[0] <= {led_row, led_col};
                    for (int i = 1; i < LATENCY; i++)
                        dl[i] <= dl[i-1];
                end
            assign d_rc = dl[LATENCY-1];
        end
    endgenerate

    assign d_row    = d_rc[15:8];
    assign d_col    = d_rc[7:0];
    assign boundary = prev_row == 8'h80 && d_row == 8'h01;
    assign hit      = pen_edge && onehot8(d_row) && onehot8(d_col);

    // f_* collects the first hit of the frame in progress; a boundary hit opens the new frame
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            prev_row <= '0;
            f_hit <= 1'b0;
            f_pos <= '0;
        end else begin
            prev_row <= d_row;
            if (boundary || (hit && !f_hit)) begin
                f_hit <= hit;
                f_pos <= {enc8(d_row), enc8(d_col)};
            end
        end

    always_comb begin
        word = '0;
        word[LIT] = 1'b1;
        word[RED] = color_sel[0];
        word[GRN] = color_sel[1];
    end

`ifdef LIGHT_PEN_ERASE_EN
    assign wr_word = erase ? 4'b0000 : word;
`else
    logic unused_erase;
    assign unused_erase = erase;
    assign wr_word = word;
`endif

    // every decision outside WRITE is taken on the completed frame, at its boundary
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        rel_n = rel;
        pos_n = pos;
        same = f_hit && f_pos == pos;
        if (state == WRITE) begin
            if (wr_valid && wr_ready)
                state_n = en ? HOLD : IDLE;
            rel_n = 8'd0;
        end else if (!en)
            state_n = IDLE;
        else if (state == IDLE)
            state_n = SEARCH;
        else if (boundary && !f_hit) begin
            if (state == CONFIRM)
                state_n = SEARCH;
            if (state == HOLD) begin
                rel_n = rel >= RF ? rel : rel + 8'd1;
                state_n = rel_n >= RF ? SEARCH : HOLD;
            end
        end else if (boundary && state == HOLD && same)
            rel_n = 8'd0;
        else if (boundary) begin
            cnt_n = state == CONFIRM && same ? (cnt >= CF ? cnt : cnt + 8'd1) : 8'd1;
            pos_n = f_pos;
            state_n = cnt_n >= CF ? WRITE : CONFIRM;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            rel <= '0;
            pos <= '0;
            wr_valid <= 1'b0;
            {wr_row, wr_col} <= '0;
            wr_data <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            rel <= rel_n;
            pos <= pos_n;
            if (state != WRITE && state_n == WRITE) begin
                wr_valid <= 1'b1;
                {wr_row, wr_col} <= pos_n;
                wr_data <= wr_word;
            end else if (wr_valid && wr_ready)
                wr_valid <= 1'b0;
        end

    assign pen_locked = state == HOLD;

endmodule
